// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : core_pkg                                                        |
// | Purpose  : Shared types for the core MEM stage: access direction, access   |
// |            size, LR/SC reservation request and MEM-stage FSM state.        |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package core_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_dir_e;

  typedef enum logic [2:0] {
    SZ_B  = 3'd0,
    SZ_H  = 3'd1,
    SZ_W  = 3'd2,
    SZ_BU = 3'd3,
    SZ_HU = 3'd4
  } mem_size_e;

  typedef enum logic [1:0] {
    RSV_NONE  = 2'd0,
    RSV_SET   = 2'd1,
    RSV_CHECK = 2'd2
  } mem_rsv_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } mem_state_e;

  // Right-aligned byte-lane mask for an access size, before shifting into place.
  function automatic logic [3:0] size_mask(input mem_size_e size);
    logic [3:0] mask;
    case (size)
      SZ_B, SZ_BU: mask = 4'b0001;
      SZ_H, SZ_HU: mask = 4'b0011;
      default:     mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_mem_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : core_mem_align                                                  |
// | Purpose  : Combinational data-bus lane formatting. Store side produces     |
// |            byte strobes and lane-replicated write data; load side selects  |
// |            the addressed lane and sign/zero-extends it.                    |
// | Ports    : i_addr_lo  - byte offset within the word                        |
// |            i_size     - access size                                        |
// |            i_wdata    - right-aligned store data                           |
// |            i_rdata    - raw bus read word                                  |
// |            o_wstrb    - byte strobes                                       |
// |            o_wdata    - replicated store data                              |
// |            o_rdata    - aligned, extended load data                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module core_mem_align
  import core_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  mem_size_e   i_size,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  // Misaligned size/offset pairs simply truncate here; EXEC never issues them.
  assign o_wstrb   = size_mask(i_size) << i_addr_lo;
  // Bring the addressed byte/half down to bit 0 so one extraction serves all lanes.
  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_wdata = i_wdata;
    o_rdata = w_shifted;
    case (i_size)
      SZ_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_BU: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {24'h000000, w_shifted[7:0]};
      end
      SZ_H: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      SZ_HU: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {16'h0000, w_shifted[15:0]};
      end
      default: begin
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/core_stage_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : core_stage_mem                                                  |
// | Purpose  : MEM pipeline stage. Issues one outstanding data-bus access per  |
// |            controller request, formats store lanes, aligns/extends loads,  |
// |            tracks the LR/SC reservation and reports access faults.         |
// | Config   : CORE_DBUS_TIMEOUT_EN - when defined, a response that has not    |
// |            arrived after TIMEOUT_CYCLES cycles in RSP completes the access |
// |            with an access fault. Undefined: RSP waits indefinitely.        |
// | Ports    : clk, rst_n               - clock, async active-low reset        |
// |            mem_stage_valid/_ready   - controller handshake (ready = pulse) |
// |            mem_addr/wdata/dir/size/rsv - request from EXEC                 |
// |            rsv_clear                - drop reservation (trap/xret)         |
// |            mem_rsv_valid            - reservation hit for mem_addr         |
// |            mem_last_rdata           - last successful load result          |
// |            dbus_req_* / dbus_addr/we/wstrb/wdata - bus request channel     |
// |            dbus_rsp_valid/err, dbus_rdata        - bus response channel    |
// |            ex_load/store_access_fault - fault pulses, aligned with ready   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module core_stage_mem
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_stage_valid,
  output logic        mem_stage_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  mem_dir_e    mem_dir,
  input  mem_size_e   mem_size,
  input  mem_rsv_e    mem_rsv,
  input  logic        rsv_clear,
  output logic        mem_rsv_valid,
  output logic [31:0] mem_last_rdata,
  output logic        dbus_req_valid,
  input  logic        dbus_req_ready,
  output logic [31:0] dbus_addr,
  output logic        dbus_we,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_rsp_valid,
  input  logic        dbus_rsp_err,
  input  logic [31:0] dbus_rdata,
  output logic        ex_load_access_fault,
  output logic        ex_store_access_fault
);

  mem_state_e  r_state;
  mem_state_e  w_state_nxt;

  logic [31:0] r_addr;
  mem_size_e   r_size;
  mem_dir_e    r_dir;
  mem_rsv_e    r_rsv;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;

  logic        r_rsv_valid;
  logic [29:0] r_rsv_addr;
  logic [31:0] r_last_rdata;

  logic        w_idle;
  logic        w_accept;
  logic [1:0]  w_sel_addr_lo;
  mem_size_e   w_sel_size;
  logic [3:0]  w_fmt_wstrb;
  logic [31:0] w_fmt_wdata;
  logic [31:0] w_ld_data;
  logic        w_timeout;
  logic        w_done;
  logic        w_err;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && mem_stage_valid;

  // The aligner sees the live request while IDLE (store formatting for the
  // first request cycle) and the latched request afterwards (load extraction).
  assign w_sel_addr_lo = w_idle ? mem_addr[1:0] : r_addr[1:0];
  assign w_sel_size    = w_idle ? mem_size      : r_size;

  core_mem_align u_align (
    .i_addr_lo (w_sel_addr_lo),
    .i_size    (w_sel_size),
    .i_wdata   (mem_wdata),
    .i_rdata   (dbus_rdata),
    .o_wstrb   (w_fmt_wstrb),
    .o_wdata   (w_fmt_wdata),
    .o_rdata   (w_ld_data)
  );

`ifdef CORE_DBUS_TIMEOUT_EN
  localparam int unsigned c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Counter reads 0 in the first RSP cycle; the TIMEOUT_CYCLES-th RSP cycle
  // without a response is the one that completes with a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != RSP) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  assign w_timeout = (r_state == RSP) && (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done = (r_state == RSP) && (dbus_rsp_valid || w_timeout);
  // A real response wins over a same-cycle timeout; a timeout alone is an error.
  assign w_err  = dbus_rsp_valid ? dbus_rsp_err : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt           = r_state;
    dbus_req_valid        = 1'b0;
    dbus_addr             = 32'h0;
    dbus_we               = 1'b0;
    dbus_wstrb            = 4'h0;
    dbus_wdata            = 32'h0;
    mem_stage_ready       = 1'b0;
    ex_load_access_fault  = 1'b0;
    ex_store_access_fault = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_stage_valid) begin
          dbus_req_valid = 1'b1;
          dbus_addr      = {mem_addr[31:2], 2'b00};
          dbus_we        = (mem_dir == MEM_WRITE);
          dbus_wstrb     = w_fmt_wstrb;
          dbus_wdata     = w_fmt_wdata;
          w_state_nxt    = dbus_req_ready ? RSP : REQ;
        end
      end
      REQ: begin
        dbus_req_valid = 1'b1;
        dbus_addr      = {r_addr[31:2], 2'b00};
        dbus_we        = (r_dir == MEM_WRITE);
        dbus_wstrb     = r_wstrb;
        dbus_wdata     = r_wdata;
        if (dbus_req_ready) begin
          w_state_nxt = RSP;
        end
      end
      RSP: begin
        if (w_done) begin
          mem_stage_ready       = 1'b1;
          ex_load_access_fault  = w_err && (r_dir == MEM_READ);
          ex_store_access_fault = w_err && (r_dir == MEM_WRITE);
          w_state_nxt           = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request capture: held stable for the REQ phase and used for the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= 32'h0;
      r_size  <= SZ_W;
      r_dir   <= MEM_READ;
      r_rsv   <= RSV_NONE;
      r_wstrb <= 4'h0;
      r_wdata <= 32'h0;
    end else if (w_accept) begin
      r_addr  <= mem_addr;
      r_size  <= mem_size;
      r_dir   <= mem_dir;
      r_rsv   <= mem_rsv;
      r_wstrb <= w_fmt_wstrb;
      r_wdata <= w_fmt_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_rdata <= 32'h0;
      r_rsv_valid  <= 1'b0;
      r_rsv_addr   <= 30'h0;
    end else begin
      if (w_done && (r_dir == MEM_READ) && !w_err) begin
        r_last_rdata <= w_ld_data;
      end
      // rsv_clear outranks a reservation being set in the same cycle.
      if (rsv_clear) begin
        r_rsv_valid <= 1'b0;
      end else if (w_done) begin
        if (r_rsv == RSV_CHECK) begin
          r_rsv_valid <= 1'b0;
        end else if ((r_rsv == RSV_SET) && (r_dir == MEM_READ)) begin
          if (w_err) begin
            r_rsv_valid <= 1'b0;
          end else begin
            r_rsv_valid <= 1'b1;
            r_rsv_addr  <= r_addr[31:2];
          end
        end
      end
    end
  end

  assign mem_last_rdata = r_last_rdata;
  // Compared against the live address so EXEC can evaluate SC before issuing.
  assign mem_rsv_valid  = r_rsv_valid && (r_rsv_addr == mem_addr[31:2]);

endmodule
`default_nettype wire
